// File: rtl/usb_fs_rx_pkg.sv
// rtl/usb_fs_rx_pkg.sv - shared line-state, FSM and protocol constants for the FS USB receiver
package usb_fs_rx_pkg;

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_EOP  = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    // SYNC decodes as seven 0s followed by a single 1
    localparam int SYNC_ZEROS = 7;

    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    function automatic logic nrzi_decode(input logic [1:0] cur, input logic [1:0] prev);
        return cur == prev;
    endfunction

endpackage

// File: rtl/usb_fs_dpll.sv
// rtl/usb_fs_dpll.sv - line synchronizer, line-state decode and 4x bit-timing recovery
module usb_fs_dpll
    import usb_fs_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_48,
    input  logic       rst,
    input  logic       rx_j,
    input  logic       rx_se0,
    output logic [1:0] line_state,
    output logic       bit_strobe
);

    logic [SYNC_STAGES-1:0] j_sync;
    logic [SYNC_STAGES-1:0] se0_sync;
    logic [1:0]             prev_state;
    logic [1:0]             phase;
    logic [1:0]             phase_now;
    logic                   jk_edge;

    always_comb begin
        if (se0_sync[SYNC_STAGES-1])
            line_state = LS_SE0;
        else if (j_sync[SYNC_STAGES-1])
            line_state = LS_J;
        else
            line_state = LS_K;
    end

    // Only J<->K edges realign the phase; SE0 entry/exit carries no timing here
    assign jk_edge    = (line_state != LS_SE0) && (prev_state != LS_SE0) && (line_state != prev_state);
    assign phase_now  = jk_edge ? 2'd0 : phase;
    assign bit_strobe = (phase_now == 2'd2);

    always_ff @(posedge clk_48) begin
        if (rst) begin
            j_sync     <= '1;
            se0_sync   <= '0;
            prev_state <= LS_J;
            phase      <= 2'd0;
        end else begin
            j_sync     <= {j_sync[SYNC_STAGES-2:0], rx_j};
            se0_sync   <= {se0_sync[SYNC_STAGES-2:0], rx_se0};
            prev_state <= line_state;
            phase      <= phase_now + 2'd1;
        end
    end

endmodule

// File: rtl/usb_fs_rx.sv
// rtl/usb_fs_rx.sv - full-speed USB receive front-end: NRZI decode, unstuffing and packet framing
module usb_fs_rx
    import usb_fs_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ONES    = 6
) (
    input  logic       clk_48,
    input  logic       rst,
    input  logic       rx_j,
    input  logic       rx_se0,
    input  logic       tx_en,
    output logic       rx_active,
    output logic       pkt_start,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       pkt_end,
    output logic       rx_err
);

    localparam int ONES_W = $clog2(MAX_ONES + 1);

    logic [1:0]        line_state;
    logic              bit_strobe;
    logic [1:0]        prev_sample;
    logic              dec_bit;
    logic [2:0]        state;
    logic [2:0]        cnt;
    logic [ONES_W-1:0] ones;
    logic [7:0]        shreg;

    usb_fs_dpll #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_dpll (
        .clk_48    (clk_48),
        .rst       (rst),
        .rx_j      (rx_j),
        .rx_se0    (rx_se0),
        .line_state(line_state),
        .bit_strobe(bit_strobe)
    );

    assign dec_bit = nrzi_decode(line_state, prev_sample);

    // cnt is reused: SYNC zero count, DATA bit index mod 8, ERR consecutive-J count
    always_ff @(posedge clk_48) begin
        if (rst) begin
            state       <= ST_IDLE;
            prev_sample <= LS_J;
            cnt         <= 3'd0;
            ones        <= '0;
            shreg       <= 8'h00;
            data        <= 8'h00;
            rx_active   <= 1'b0;
            pkt_start   <= 1'b0;
            data_valid  <= 1'b0;
            pkt_end     <= 1'b0;
            rx_err      <= 1'b0;
        end else begin
            pkt_start  <= 1'b0;
            data_valid <= 1'b0;
            pkt_end    <= 1'b0;
            rx_err     <= 1'b0;
            if (bit_strobe)
                prev_sample <= line_state;

            if (tx_en) begin
                state     <= ST_IDLE;
                rx_active <= 1'b0;
            end else if (bit_strobe) begin
                case (state)
                    ST_IDLE: begin
                        if (line_state == LS_K && prev_sample == LS_J) begin
                            state <= ST_SYNC;
                            cnt   <= 3'd1;
                        end
                    end
                    ST_SYNC: begin
                        if (line_state == LS_SE0) begin
                            state  <= ST_IDLE;
                            rx_err <= 1'b1;
                        end else if (cnt < 3'(SYNC_ZEROS)) begin
                            if (dec_bit)
                                state <= ST_IDLE;
                            else
                                cnt <= cnt + 3'd1;
                        end else if (dec_bit) begin
                            state     <= ST_DATA;
                            pkt_start <= 1'b1;
                            rx_active <= 1'b1;
                            cnt       <= 3'd0;
                            ones      <= ONES_W'(1);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        if (line_state == LS_SE0) begin
                            state <= ST_EOP;
                        end else if (ones == ONES_W'(MAX_ONES)) begin
                            if (dec_bit) begin
                                state     <= ST_ERR;
                                rx_err    <= 1'b1;
                                rx_active <= 1'b0;
                                cnt       <= 3'd0;
                            end else begin
                                ones <= '0;
                            end
                        end else begin
                            shreg <= {dec_bit, shreg[7:1]};
                            cnt   <= cnt + 3'd1;
                            ones  <= dec_bit ? ones + ONES_W'(1) : '0;
                            if (cnt == 3'd7) begin
                                data       <= {dec_bit, shreg[7:1]};
                                data_valid <= 1'b1;
                            end
                        end
                    end
                    ST_EOP: begin
                        if (line_state == LS_J) begin
                            state     <= ST_IDLE;
                            rx_active <= 1'b0;
                            if (cnt == 3'd0)
                                pkt_end <= 1'b1;
                            else
                                rx_err <= 1'b1;
                        end else if (line_state == LS_K) begin
                            state     <= ST_ERR;
                            rx_err    <= 1'b1;
                            rx_active <= 1'b0;
                            cnt       <= 3'd0;
                        end
                    end
                    ST_ERR: begin
                        if (line_state == LS_J) begin
                            if (cnt == 3'd1)
                                state <= ST_IDLE;
                            else
                                cnt <= cnt + 3'd1;
                        end else begin
                            cnt <= 3'd0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_fs_rx.sv
// tb/tb_usb_fs_rx.sv - self-checking bench for usb_fs_rx against a packet-level reference model
module tb_usb_fs_rx;
    import usb_fs_rx_pkg::*;

    localparam int BENCH_MAX_ONES = 6;
    localparam int SYM_SE0 = 0;
    localparam int SYM_J   = 1;
    localparam int SYM_K   = 2;

    logic       clk_48 = 1'b0;
    logic       rst = 1'b1;
    logic       rx_j = 1'b1;
    logic       rx_se0 = 1'b0;
    logic       tx_en = 1'b0;
    logic       rx_active;
    logic       pkt_start;
    logic [7:0] data;
    logic       data_valid;
    logic       pkt_end;
    logic       rx_err;

    int         checks = 0;
    int         errors = 0;
    int         n_start, n_end, n_err;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    bit         exp_err;
    bit         data_bits[$];
    int         sym_q[$];
    bit         level;
    bit         jitter = 1'b0;
    int         off = 0;
    logic       tx_prev = 1'b0;

    usb_fs_rx u_dut (
        .clk_48    (clk_48),
        .rst       (rst),
        .rx_j      (rx_j),
        .rx_se0    (rx_se0),
        .tx_en     (tx_en),
        .rx_active (rx_active),
        .pkt_start (pkt_start),
        .data      (data),
        .data_valid(data_valid),
        .pkt_end   (pkt_end),
        .rx_err    (rx_err)
    );

    always #5 clk_48 = ~clk_48;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_48) begin
        if (!rst) begin
            if (pkt_start) n_start++;
            if (data_valid) got_q.push_back(data);
            if (pkt_end) n_end++;
            if (rx_err) n_err++;
            if (pkt_end || rx_err || data_valid) begin
                check("end_err_exclusive", {31'd0, pkt_end & rx_err}, 32'd0);
                check("valid_end_exclusive", {31'd0, data_valid & pkt_end}, 32'd0);
            end
            if (data_valid) check("active_on_valid", {31'd0, rx_active}, 32'd1);
            if (tx_prev)
                check("tx_quiet", {27'd0, rx_active, pkt_start, data_valid, pkt_end, rx_err}, 32'd0);
        end
        tx_prev = tx_en;
    end

    task automatic add_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) data_bits.push_back(b[i]);
    endtask

    task automatic push_level(input bit b);
        if (!b) level = ~level;
        sym_q.push_back(level ? SYM_J : SYM_K);
    endtask

    // Encode SYNC + data (NRZI, bit stuffing) + EOP + idle, and derive the expected outcome
    task automatic build_packet(input bit fault);
        int         ones;
        int         nbits;
        bit         faulted;
        logic [7:0] acc;
        sym_q.delete();
        exp_q.delete();
        level = 1'b1;
        acc = 8'h00;
        for (int i = 0; i < 7; i++) push_level(1'b0);
        push_level(1'b1);
        ones = 1;
        nbits = 0;
        faulted = 1'b0;
        for (int i = 0; i < data_bits.size() && !faulted; i++) begin
            push_level(data_bits[i]);
            acc[nbits % 8] = data_bits[i];
            nbits++;
            if (nbits % 8 == 0) exp_q.push_back(acc);
            ones = data_bits[i] ? ones + 1 : 0;
            if (ones == BENCH_MAX_ONES) begin
                if (fault) begin
                    push_level(1'b1);
                    faulted = 1'b1;
                end else begin
                    push_level(1'b0);
                    ones = 0;
                end
            end
        end
        exp_err = faulted || (nbits % 8 != 0);
        sym_q.push_back(SYM_SE0);
        sym_q.push_back(SYM_SE0);
        for (int i = 0; i < 9; i++) sym_q.push_back(SYM_J);
    endtask

    task automatic drive_sym(input int sym);
        int len;
        if (!jitter) begin
            len = 4;
        end else begin
            len = (off == 0) ? 3 + int'($urandom_range(0, 1)) : 4 + int'($urandom_range(0, 1));
            off += len - 4;
        end
        rx_se0 = (sym == SYM_SE0);
        rx_j   = (sym == SYM_SE0) ? 1'($urandom_range(0, 1)) : (sym == SYM_J);
        repeat (len) @(posedge clk_48);
        #1;
    endtask

    task automatic drive_range(input int from, input int to);
        for (int i = from; i < to; i++) drive_sym(sym_q[i]);
    endtask

    task automatic clear_counts();
        n_start = 0;
        n_end = 0;
        n_err = 0;
        got_q.delete();
    endtask

    task automatic run_packet(input string tag, input bit fault);
        build_packet(fault);
        clear_counts();
        drive_range(0, sym_q.size());
        check({tag, "_start"}, n_start, 1);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        check({tag, "_end"}, n_end, exp_err ? 0 : 1);
        check({tag, "_err"}, n_err, exp_err ? 1 : 0);
        check({tag, "_active_after"}, {31'd0, rx_active}, 32'd0);
    endtask

    initial begin
        repeat (4) @(posedge clk_48);
        #1;
        rst = 1'b0;
        check("reset_outputs", {19'd0, rx_active, pkt_start, data_valid, pkt_end, rx_err, data}, 32'd0);
        clear_counts();
        for (int i = 0; i < 8; i++) drive_sym(SYM_J);

        data_bits.delete(); add_byte(PID_ACK);
        run_packet("ack", 1'b0);

        data_bits.delete(); add_byte(8'hFF); add_byte(8'hFF);
        run_packet("ff_stuffed", 1'b0);

        data_bits.delete(); add_byte(8'hFF); add_byte(8'hFF);
        run_packet("stuff_violation", 1'b1);

        data_bits.delete(); add_byte(PID_ACK);
        run_packet("recover_ack", 1'b0);

        data_bits.delete();
        for (int i = 0; i < 5; i++) data_bits.push_back(1'($urandom_range(0, 1)));
        run_packet("short_5bits", 1'b0);

        for (int p = 0; p < 3; p++) begin
            data_bits.delete();
            for (int i = 0; i < 1 + int'($urandom_range(0, 5)); i++) add_byte(8'($urandom));
            if (p == 2)
                for (int i = 0; i < 1 + int'($urandom_range(0, 6)); i++)
                    data_bits.push_back(1'($urandom_range(0, 1)));
            run_packet("random_pkt", 1'b0);
        end

        jitter = 1'b1;
        data_bits.delete();
        for (int i = 0; i < 64; i++) add_byte(8'($urandom));
        run_packet("jitter_64", 1'b0);
        jitter = 1'b0;

        // Reset in the middle of the second byte
        data_bits.delete(); add_byte(8'hA5); add_byte(8'h3C);
        build_packet(1'b0);
        clear_counts();
        drive_range(0, 19);
        check("pre_rst_nbytes", got_q.size(), 1);
        check("pre_rst_byte", {24'd0, got_q.size() > 0 ? got_q[0] : 8'hxx}, 32'hA5);
        rst = 1'b1;
        rx_j = 1'b1;
        rx_se0 = 1'b0;
        @(posedge clk_48);
        #1;
        check("mid_rst_outputs", {19'd0, rx_active, pkt_start, data_valid, pkt_end, rx_err, data}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) drive_sym(SYM_J);
        check("post_rst_end", n_end, 0);
        check("post_rst_err", n_err, 0);
        check("post_rst_nbytes", got_q.size(), 1);

        // Own transmission echoed back mid-packet
        data_bits.delete();
        for (int i = 0; i < 3; i++) add_byte(8'($urandom));
        build_packet(1'b0);
        clear_counts();
        drive_range(0, 20);
        tx_en = 1'b1;
        drive_range(20, sym_q.size());
        for (int i = 0; i < 4; i++) drive_sym(SYM_J);
        tx_en = 1'b0;
        for (int i = 0; i < 8; i++) drive_sym(SYM_J);
        check("tx_start", n_start, 1);
        check("tx_nbytes", got_q.size(), 1);
        check("tx_byte", {24'd0, got_q.size() > 0 ? got_q[0] : 8'hxx}, {24'd0, exp_q[0]});
        check("tx_end", n_end, 0);
        check("tx_err", n_err, 0);
        check("tx_active", {31'd0, rx_active}, 32'd0);

        data_bits.delete(); add_byte(PID_NAK); add_byte(8'($urandom));
        run_packet("after_tx", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
